acc_deserializer: RTL
=====================

# acc_deserializer

Serial-to-parallel receiver for the accumulator datapath: collects a stream of single bits, one per qualified cycle, into an N-bit word and hands the completed word to the accumulator load path through a one-entry valid/ready output buffer. It is the receiving end of the accumulator's shift-in/shift-out traffic. Each frame uses the same two shift orderings as the accumulator shifter: left-shift order (MSB-first) or right-shift order (LSB-first).

## Interface
- N, 8, word width in bits (N ≥ 2).
- CNT_W, 3, bit-counter width; must equal ceil(log2(N)).
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle strobe; begins a new frame and discards any partial frame.
- dir  in  1  framing order, sampled only on start. 0 = left-shift order: bits enter bit 0 and move toward the MSB, so the first bit ends at the MSB. 1 = right-shift order: bits enter bit N-1 and move toward bit 0, so the first bit ends at the LSB.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is valid this cycle.
- abort  in  1  drops the partial frame and returns to IDLE.
- busy  out  1  high while a frame is in progress.
- word_out  out  N  completed word (output buffer contents).
- word_valid  out  1  output buffer holds an unconsumed word.
- word_ready  in  1  downstream accepts word_out this cycle.
- overrun  out  1  sticky; a completed word was dropped because the buffer was full.

## Operation
- Reset (clr=1): state IDLE, shift register 0, bit count 0, latched dir 0, busy 0, word_out 0, word_valid 0, overrun 0.
- Priority, highest first: clr, abort, start, sin_valid.
- IDLE state:
  - start → SHIFT; shift register cleared; count 0; dir latched.
  - sin_valid in IDLE is ignored.
- SHIFT state:
  - abort → IDLE; partial word discarded; output buffer and overrun untouched.
  - start → restart: shift register cleared, count 0, dir re-latched, stay in SHIFT. A sin_valid bit in the same cycle is dropped.
  - sin_valid → bit shifted in per the latched dir; count incremented.
  - When the shifted bit is bit N (count = N-1): go to IDLE, count 0, and the completed word is offered to the output buffer.
- Output buffer, on word completion:
  - Empty, or being drained this cycle (word_valid && word_ready): load the new word; word_valid=1.
  - Otherwise: new word discarded; overrun set. Cleared only by clr.
- Output buffer, no completion: word_valid && word_ready clears word_valid; word_out retains its last value.
- busy = (state == SHIFT).

## Timing
- Bit sampling: the start cycle never samples a bit; the first bit may arrive the cycle after start.
- Minimum frame: start plus N cycles of sin_valid; word_valid rises on the edge ending the Nth bit cycle.
- Back-to-back frames: the next start may be asserted the cycle after the last bit. Sustained throughput is N+1 cycles per word when word_ready=1.
- Handshake:
  - word_out is stable while word_valid && !word_ready.
  - word_ready is ignored when word_valid=0.
  - No combinational path from word_ready to word_valid or word_out.
- Reset mid-frame or mid-handshake: takes effect at the next edge; all outputs return to reset values.
- Gaps in sin_valid are allowed indefinitely; the count holds.

## Structure
- Shared package acc_pkg:
  - state typedef {IDLE, SHIFT}.
  - Direction constants DIR_LEFT=1'b0 and DIR_RIGHT=1'b1, matching the shifter's left/right control codes.
- Sub-module acc_word_buf: one-entry valid/ready holding register with a load-while-drain rule and overrun flag.
- The top level holds the FSM, bit counter and shift register.

## Test plan
- Left-shift order: N=8, start with dir=0, then bits 1,0,1,1,0,0,1,0 → word_out=8'hB2, word_valid=1 on the cycle after the 8th bit, busy=0.
- Right-shift order: same bits with dir=1 → word_out=8'h4D.
- Backpressure: complete 8'hB2 with word_ready=0, then complete a second frame → word_out stays 8'hB2 and overrun=1. Pulse word_ready → word_valid=0.
- Drain during completion: word_valid=1 and word_ready=1 in the cycle the second word completes → second word loaded, word_valid stays 1, overrun stays 0.
- Abort/restart: abort after 5 bits → IDLE, no word produced. Start again mid-frame after 3 bits, then 8 bits → only the 8 post-restart bits form the word.
- Reset and gaps: clr asserted mid-frame with word_valid=1 → all outputs 0 next cycle. Frame with random sin_valid gaps → same word as the gapless frame.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator datapath: deserializer FSM states
// and the left/right shift control codes used by the accumulator shifter.
package acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/acc_deserializer_if.sv
// Serial input, frame control and word valid/ready bundle of acc_deserializer.
interface acc_deserializer_if #(
    parameter int N = 8
);
    logic         start;
    logic         dir;
    logic         sin;
    logic         sin_valid;
    logic         abort;
    logic         busy;
    logic [N-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         overrun;

    modport master (
        output start, dir, sin, sin_valid, abort, word_ready,
        input  busy, word_out, word_valid, overrun
    );

    modport slave (
        input  start, dir, sin, sin_valid, abort, word_ready,
        output busy, word_out, word_valid, overrun
    );
endinterface

// File: rtl/acc_word_buf.sv
// One-entry valid/ready holding register: a word may load while the current
// one drains; a word arriving into a full, undrained buffer sets sticky overrun.
module acc_word_buf #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] word_in,
    input  logic         word_ready,
    output logic [N-1:0] word_out,
    output logic         word_valid,
    output logic         overrun
);
    logic drain;

    assign drain = word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (clr) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            if (!word_valid || drain) begin
                word_out   <= word_in;
                word_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (drain) begin
            word_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/acc_deserializer.sv
// Serial-to-parallel receiver: shifts sin into an N-bit word in left (MSB-first)
// or right (LSB-first) order and hands finished words to acc_word_buf.
module acc_deserializer
    import acc_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 3
) (
    input logic              clk,
    input logic              clr,
    acc_deserializer_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [N-1:0]     sr_q, sr_d, sr_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             load;

    // The completed word is taken from the shifted value so it loads on the
    // same edge that consumes the final bit.
    assign sr_shift = (dir_q == DIR_LEFT) ? {sr_q[N-2:0], bus.sin}
                                          : {bus.sin, sr_q[N-1:1]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.abort && bus.start) begin
                    state_d = SHIFT;
                    sr_d    = '0;
                    cnt_d   = '0;
                    dir_d   = bus.dir;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                end else if (bus.start) begin
                    sr_d  = '0;
                    cnt_d = '0;
                    dir_d = bus.dir;
                end else if (bus.sin_valid) begin
                    sr_d = sr_shift;
                    if (cnt_q == LAST_BIT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);

    acc_word_buf #(.N(N)) u_buf (
        .clk        (clk),
        .clr        (clr),
        .load       (load),
        .word_in    (sr_shift),
        .word_ready (bus.word_ready),
        .word_out   (bus.word_out),
        .word_valid (bus.word_valid),
        .overrun    (bus.overrun)
    );
endmodule
